// File: rtl/mips_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one Avalon-MM RAM slave, one transaction at a time.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for alternating grants; default build gives DATA fixed priority.
module mips_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                m_read,
    output logic                m_write,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
    typedef enum logic {OWN_DATA = 1'b0, OWN_INSTR = 1'b1} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              grant;
    logic [DATA_W-1:0]   i_hold_q, i_hold_d;
    logic [DATA_W-1:0]   d_hold_q, d_hold_d;
    logic                i_pend, d_pend, issue_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e              last_grant_q, last_grant_d;
`endif

    assign i_pend      = i_read;
    assign d_pend      = d_read | d_write;
    // A simultaneous d_read/d_write is a write.
    assign issue_write = (owner_q == OWN_DATA) && d_write;

    always_comb begin
        grant = OWN_DATA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_pend && d_pend)
            grant = (last_grant_q == OWN_DATA) ? OWN_INSTR : OWN_DATA;
        else if (i_pend)
            grant = OWN_INSTR;
`else
        if (!d_pend && i_pend)
            grant = OWN_INSTR;
`endif
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        i_hold_d = i_hold_q;
        d_hold_d = d_hold_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_pend || d_pend) begin
                    owner_d = grant;
                    state_d = S_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant;
`endif
                end
            end
            S_ISSUE: begin
                if (!m_waitrequest)
                    state_d = issue_write ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (owner_q == OWN_INSTR) i_hold_d = m_readdata;
                else                      d_hold_d = m_readdata;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_DATA;
            i_hold_q <= '0;
            d_hold_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= OWN_DATA;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            i_hold_q <= i_hold_d;
            d_hold_q <= d_hold_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Master side is only live in ISSUE, so reset forces it idle without waiting for an edge.
    always_comb begin
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;
        m_byteenable = '0;
        if (state_q == S_ISSUE) begin
            if (owner_q == OWN_INSTR) begin
                m_read       = 1'b1;
                m_address    = i_address;
                m_byteenable = '1;
            end else begin
                m_write      = d_write;
                m_read       = d_read & ~d_write;
                m_address    = d_address;
                m_writedata  = d_writedata;
                m_byteenable = d_byteenable;
            end
        end
    end

    assign i_waitrequest = !((state_q == S_RESP) && (owner_q == OWN_INSTR));
    assign d_waitrequest = !(((state_q == S_RESP) && (owner_q == OWN_DATA)) ||
                             ((state_q == S_ISSUE) && issue_write && !m_waitrequest));

    assign i_readdata = ((state_q == S_RESP) && (owner_q == OWN_INSTR)) ? m_readdata : i_hold_q;
    assign d_readdata = ((state_q == S_RESP) && (owner_q == OWN_DATA))  ? m_readdata : d_hold_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a zero/stallable-wait registered RAM model.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_address = '0;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = '0;
    logic [31:0] d_writedata = '0;
    logic [3:0]  d_byteenable = '0;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic        m_read, m_write;
    logic [31:0] m_address, m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    logic        ram_stall = 1'b0;
    logic [31:0] mem [0:15];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_mread = 0;
    int          n_mwrite = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_address(i_address),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata)
    );

    // RAM model: word index from address bits [5:2], registered read data.
    assign m_waitrequest = ram_stall;
    always @(posedge clk) begin
        if (m_read && !m_waitrequest)
            m_readdata <= mem[m_address[5:2]];
        if (m_write && !m_waitrequest)
            for (int b = 0; b < 4; b++)
                if (m_byteenable[b])
                    mem[m_address[5:2]][8*b +: 8] <= m_writedata[8*b +: 8];
    end

    always @(negedge clk) begin
        if (m_read)  n_mread++;
        if (m_write) n_mwrite++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // All request tasks start just after a rising edge and return just after one.
    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] data, output int cyc);
        i_address = addr;
        i_read    = 1'b1;
        cyc  = 0;
        data = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!i_waitrequest) begin
                cyc  = k;
                data = i_readdata;
                check_eq("fetch_dwait_nonowner", {31'd0, d_waitrequest}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic do_dread(input logic [31:0] addr, output logic [31:0] data, output int cyc);
        d_address = addr;
        d_read    = 1'b1;
        cyc  = 0;
        data = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!d_waitrequest) begin
                cyc  = k;
                data = d_readdata;
                break;
            end
        end
        @(posedge clk); #1;
        d_read = 1'b0;
    endtask

    task automatic do_dwrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                             output int cyc, output logic mw, output logic [3:0] mbe);
        d_address    = addr;
        d_writedata  = wdata;
        d_byteenable = be;
        d_write      = 1'b1;
        cyc = 0;
        mw  = 1'b0;
        mbe = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!d_waitrequest) begin
                cyc = k;
                mw  = m_write;
                mbe = m_byteenable;
                break;
            end
        end
        @(posedge clk); #1;
        d_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd2;
        int          cyc, cyc2, base;
        logic        mw;
        logic [3:0]  mbe;

        for (int w = 0; w < 16; w++) mem[w] = '0;
        mem[0] = 32'hDEADBEEF;
        mem[2] = 32'hCAFEF00D;

        // Reset state
        #12;
        check_eq("rst_iwait", {31'd0, i_waitrequest}, 32'd1);
        check_eq("rst_dwait", {31'd0, d_waitrequest}, 32'd1);
        check_eq("rst_mrw", {30'd0, m_read, m_write}, 32'd0);
        check_eq("rst_maddr", m_address, 32'd0);
        check_eq("rst_irdata", i_readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: single fetch
        base = n_mread;
        do_fetch(32'hBFC00000, rd, cyc);
        check_eq("t1_cyc", cyc, 3);
        check_eq("t1_data", rd, 32'hDEADBEEF);
        check_eq("t1_mread_cycles", n_mread - base, 1);
        @(negedge clk);
        check_eq("t1_irdata_hold", i_readdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // 2: partial write then readback
        base = n_mwrite;
        do_dwrite(32'hBFC00004, 32'h12345678, 4'b0011, cyc, mw, mbe);
        check_eq("t2_cyc", cyc, 2);
        check_eq("t2_mwrite", {31'd0, mw}, 32'd1);
        check_eq("t2_mbe", {28'd0, mbe}, 32'h3);
        check_eq("t2_mwrite_cycles", n_mwrite - base, 1);
        do_dread(32'hBFC00004, rd, cyc);
        check_eq("t2_rb_cyc", cyc, 3);
        check_eq("t2_rb_data", rd, 32'h00005678);

        // 3: simultaneous fetch and data read
        fork
            do_fetch(32'hBFC00008, rd, cyc);
            do_dread(32'hBFC00000, rd2, cyc2);
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check_eq("t3_fetch_cyc", cyc, 3);
        check_eq("t3_data_cyc", cyc2, 6);
`else
        check_eq("t3_fetch_cyc", cyc, 6);
        check_eq("t3_data_cyc", cyc2, 3);
`endif
        check_eq("t3_fetch_data", rd, 32'hCAFEF00D);
        check_eq("t3_data_data", rd2, 32'hDEADBEEF);

        // 4: RAM stalls the data read for 3 cycles of ISSUE
        ram_stall = 1'b1;
        fork
            do_dread(32'hBFC00004, rd, cyc);
            begin
                @(negedge clk);
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check_eq("t4_stall_mread", {31'd0, m_read}, 32'd1);
                    check_eq("t4_stall_maddr", m_address, 32'hBFC00004);
                    check_eq("t4_stall_dwait", {31'd0, d_waitrequest}, 32'd1);
                end
                @(posedge clk); #1;
                ram_stall = 1'b0;
            end
        join
        check_eq("t4_cyc", cyc, 6);
        check_eq("t4_data", rd, 32'h00005678);

        // 5: reset asserted while the fetch is in RESP
        i_address = 32'hBFC00008;
        i_read    = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check_eq("t5_in_resp_iwait", {31'd0, i_waitrequest}, 32'd0);
        check_eq("t5_in_resp_data", i_readdata, 32'hCAFEF00D);
        #1 reset_n = 1'b0;
        #1;
        check_eq("t5_rst_waits", {30'd0, i_waitrequest, d_waitrequest}, 32'h3);
        check_eq("t5_rst_mrw", {30'd0, m_read, m_write}, 32'd0);
        check_eq("t5_rst_irdata", i_readdata, 32'd0);
        check_eq("t5_rst_drdata", d_readdata, 32'd0);
        i_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_fetch(32'hBFC00000, rd, cyc);
        check_eq("t5_after_cyc", cyc, 3);
        check_eq("t5_after_data", rd, 32'hDEADBEEF);

        // 6: back-to-back fetches, data port idle
        base = n_mread;
        do_fetch(32'hBFC00000, rd, cyc);
        check_eq("t6_a_cyc", cyc, 3);
        check_eq("t6_a_data", rd, 32'hDEADBEEF);
        do_fetch(32'hBFC00004, rd, cyc);
        check_eq("t6_b_cyc", cyc, 3);
        check_eq("t6_b_data", rd, 32'h00005678);
        do_fetch(32'hBFC00008, rd, cyc);
        check_eq("t6_c_cyc", cyc, 3);
        check_eq("t6_c_data", rd, 32'hCAFEF00D);
        check_eq("t6_mread_cycles", n_mread - base, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
